// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift/rotate left/right, parallel load and clear,
// with a saturating count of shift positions since the last load/clear/reset.
module univ_shift_reg #(
    parameter int                 WIDTH     = 8,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0,
    localparam int                CNT_W     = $clog2(WIDTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [2:0]       i_mode,
    input  logic             i_sin,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q,
    output logic             o_sout,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_drained
);

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'b000,
        MODE_SHL   = 3'b001,
        MODE_SHR   = 3'b010,
        MODE_ROL   = 3'b011,
        MODE_ROR   = 3'b100,
        MODE_LOAD  = 3'b101,
        MODE_CLEAR = 3'b110,
        MODE_RSVD  = 3'b111
    } mode_t;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

    logic [WIDTH-1:0] q_nxt;
    logic             sout_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cnt_inc;

    // Counter saturates at WIDTH; the shift itself still happens.
    assign cnt_inc = (o_cnt == CNT_FULL) ? o_cnt : o_cnt + CNT_W'(1);

    always_comb begin
        q_nxt    = o_q;
        sout_nxt = o_sout;
        cnt_nxt  = o_cnt;
        case (mode_t'(i_mode))
            MODE_SHL: begin
                q_nxt    = {o_q[WIDTH-2:0], i_sin};
                sout_nxt = o_q[WIDTH-1];
                cnt_nxt  = cnt_inc;
            end
            MODE_SHR: begin
                q_nxt    = {i_sin, o_q[WIDTH-1:1]};
                sout_nxt = o_q[0];
                cnt_nxt  = cnt_inc;
            end
            MODE_ROL: begin
                q_nxt    = {o_q[WIDTH-2:0], o_q[WIDTH-1]};
                sout_nxt = o_q[WIDTH-1];
                cnt_nxt  = cnt_inc;
            end
            MODE_ROR: begin
                q_nxt    = {o_q[0], o_q[WIDTH-1:1]};
                sout_nxt = o_q[0];
                cnt_nxt  = cnt_inc;
            end
            MODE_LOAD: begin
                q_nxt   = i_d;
                cnt_nxt = '0;
            end
            MODE_CLEAR: begin
                q_nxt    = '0;
                sout_nxt = 1'b0;
                cnt_nxt  = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_q    <= RESET_VAL;
            o_sout <= 1'b0;
            o_cnt  <= '0;
        end else if (i_en) begin
            o_q    <= q_nxt;
            o_sout <= sout_nxt;
            o_cnt  <= cnt_nxt;
        end
    end

    assign o_drained = (o_cnt == CNT_FULL);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg: the driver queues hand-computed expectations,
// a monitor pops and compares one entry after every clock edge it covers.
module tb_univ_shift_reg;

    localparam int WIDTH = 8;
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             i_clk = 1'b0;
    logic             i_rst = 1'b1;
    logic             i_en = 1'b1;
    logic [2:0]       i_mode = 3'b101;
    logic             i_sin = 1'b0;
    logic [WIDTH-1:0] i_d = 8'hFF;
    logic [WIDTH-1:0] o_q;
    logic             o_sout;
    logic [CNT_W-1:0] o_cnt;
    logic             o_drained;

    univ_shift_reg #(.WIDTH(WIDTH), .RESET_VAL(8'h00)) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_en      (i_en),
        .i_mode    (i_mode),
        .i_sin     (i_sin),
        .i_d       (i_d),
        .o_q       (o_q),
        .o_sout    (o_sout),
        .o_cnt     (o_cnt),
        .o_drained (o_drained)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        string            name;
        logic [WIDTH-1:0] q;
        logic             sout;
        logic [CNT_W-1:0] cnt;
        logic             drained;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic step(input string name, input logic rst, input logic en,
                        input logic [2:0] mode, input logic sin, input logic [7:0] d,
                        input logic [7:0] eq, input logic es, input int ec);
        exp_t e;
        @(negedge i_clk);
        i_rst  = rst;
        i_en   = en;
        i_mode = mode;
        i_sin  = sin;
        i_d    = d;
        e.name    = name;
        e.q       = eq;
        e.sout    = es;
        e.cnt     = CNT_W'(ec);
        e.drained = (ec == WIDTH);
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge i_clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                total++;
                if (o_q !== e.q) begin
                    bad++;
                    $display("FAIL %s q: got %h want %h", e.name, o_q, e.q);
                end
                total++;
                if (o_sout !== e.sout) begin
                    bad++;
                    $display("FAIL %s sout: got %b want %b", e.name, o_sout, e.sout);
                end
                total++;
                if (o_cnt !== e.cnt) begin
                    bad++;
                    $display("FAIL %s cnt: got %0d want %0d", e.name, o_cnt, e.cnt);
                end
                total++;
                if (o_drained !== e.drained) begin
                    bad++;
                    $display("FAIL %s drained: got %b want %b", e.name, o_drained, e.drained);
                end
            end
        end
    end

    initial begin : driver
        int guard;
        // reset beats LOAD 0xFF
        step("rst0", 1, 1, 3'b101, 0, 8'hFF, 8'h00, 0, 0);
        step("rst1", 1, 1, 3'b101, 0, 8'hFF, 8'h00, 0, 0);
        // shift left
        step("ld_a5", 0, 1, 3'b101, 0, 8'hA5, 8'hA5, 0, 0);
        step("shl",   0, 1, 3'b001, 1, 8'h00, 8'h4B, 1, 1);
        // drain and saturate
        step("ld_81", 0, 1, 3'b101, 0, 8'h81, 8'h81, 1, 0);
        step("shr1",  0, 1, 3'b010, 0, 8'h00, 8'h40, 1, 1);
        step("shr2",  0, 1, 3'b010, 0, 8'h00, 8'h20, 0, 2);
        step("shr3",  0, 1, 3'b010, 0, 8'h00, 8'h10, 0, 3);
        step("shr4",  0, 1, 3'b010, 0, 8'h00, 8'h08, 0, 4);
        step("shr5",  0, 1, 3'b010, 0, 8'h00, 8'h04, 0, 5);
        step("shr6",  0, 1, 3'b010, 0, 8'h00, 8'h02, 0, 6);
        step("shr7",  0, 1, 3'b010, 0, 8'h00, 8'h01, 0, 7);
        step("shr8",  0, 1, 3'b010, 0, 8'h00, 8'h00, 1, 8);
        step("shr9",  0, 1, 3'b010, 0, 8'h00, 8'h00, 0, 8);
        // rotates; i_sin must not leak in
        step("ld_81b", 0, 1, 3'b101, 1, 8'h81, 8'h81, 0, 0);
        step("rol",    0, 1, 3'b011, 0, 8'h00, 8'h03, 1, 1);
        step("ld_81c", 0, 1, 3'b101, 0, 8'h81, 8'h81, 1, 0);
        step("ror",    0, 1, 3'b100, 0, 8'h00, 8'hC0, 1, 1);
        step("rol_s1", 0, 1, 3'b011, 1, 8'h00, 8'h81, 1, 2);
        step("ror_s0", 0, 1, 3'b100, 0, 8'h00, 8'hC0, 1, 3);
        // enable gating and clear
        step("ld_3c", 0, 1, 3'b101, 0, 8'h3C, 8'h3C, 1, 0);
        step("en0_a", 0, 0, 3'b101, 0, 8'hFF, 8'h3C, 1, 0);
        step("en0_b", 0, 0, 3'b101, 0, 8'hFF, 8'h3C, 1, 0);
        step("en0_c", 0, 0, 3'b001, 1, 8'hFF, 8'h3C, 1, 0);
        step("shl2",  0, 1, 3'b001, 0, 8'h00, 8'h78, 0, 1);
        step("clear", 0, 1, 3'b110, 1, 8'hFF, 8'h00, 0, 0);
        // reserved and hold modes
        step("ld_5a", 0, 1, 3'b101, 0, 8'h5A, 8'h5A, 0, 0);
        step("shl3",  0, 1, 3'b001, 1, 8'h00, 8'hB5, 0, 1);
        step("rsvd",  0, 1, 3'b111, 1, 8'hFF, 8'hB5, 0, 1);
        step("hold",  0, 1, 3'b000, 1, 8'hFF, 8'hB5, 0, 1);
        // reset mid-operation
        step("ld_f0",  0, 1, 3'b101, 0, 8'hF0, 8'hF0, 0, 0);
        step("shl_a",  0, 1, 3'b001, 0, 8'h00, 8'hE0, 1, 1);
        step("shl_b",  0, 1, 3'b001, 0, 8'h00, 8'hC0, 1, 2);
        step("shl_c",  0, 1, 3'b001, 0, 8'h00, 8'h80, 1, 3);
        step("rst_mid", 1, 1, 3'b001, 1, 8'h00, 8'h00, 0, 0);
        step("shl_post", 0, 1, 3'b001, 1, 8'h00, 8'h01, 0, 1);
        // loading the same value still clears the count
        step("ld_same", 0, 1, 3'b101, 0, 8'h01, 8'h01, 0, 0);
        step("shr_sat0", 0, 1, 3'b010, 1, 8'h00, 8'h80, 1, 1);

        @(negedge i_clk);
        i_en   = 1'b0;
        i_mode = 3'b000;
        guard = 0;
        while (sb.size() > 0 && guard < 20) begin
            @(negedge i_clk);
            guard++;
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain_queue: got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
